// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - framed byte-stream program loader with core write passthrough
// Holds the core in reset, loads SYNC/ADDR/LEN/DATA/CSUM frames into memory, then hands the write port to the core.
module boot_loader #(
   parameter int           n    = 8,
   parameter logic [n-1:0] SYNC = 8'hA5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [n-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] core_wr_data,
   input  logic [n-1:0] core_wr_addr,
   input  logic         core_wr_en,
   output logic [n-1:0] mem_wr_data,
   output logic [n-1:0] mem_wr_addr,
   output logic         mem_wr_en,
   output logic         core_reset,
   output logic         done,
   output logic         err
);

   localparam logic [2:0] S_SYNC = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_LEN  = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_CSUM = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;
   localparam logic [2:0] S_RUN  = 3'd6;

   localparam logic [n-1:0] ONE  = 1;
   localparam logic [n-1:0] ZERO = '0;

   logic [2:0]   state_q, state_d;
   logic [n-1:0] ptr_q, ptr_d;
   logic [n-1:0] cnt_q, cnt_d;
   logic [n-1:0] sum_q, sum_d;
   logic         err_q, err_d;
   logic         wr_en_q, wr_en_d;
   logic [n-1:0] wr_addr_q, wr_addr_d;
   logic [n-1:0] wr_data_q, wr_data_d;
   logic [1:0]   sync_q, sync_d;
   logic         accept;
   logic [n-1:0] sum_next;

   // Deassertion of reset only becomes visible to the stream port after two edges.
   assign sync_d   = {sync_q[0], 1'b1};
   assign in_ready = reset && sync_q[1] && (state_q <= S_CSUM);
   assign accept   = in_valid && in_ready;
   assign sum_next = sum_q + in_data;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      case (state_q)
         S_SYNC: begin
            if (accept && in_data == SYNC) begin
               state_d = S_ADDR;
               err_d   = 1'b0;
               sum_d   = ZERO;
            end
         end
         S_ADDR: begin
            if (accept) begin
               ptr_d   = in_data;
               sum_d   = in_data;
               state_d = S_LEN;
            end
         end
         S_LEN: begin
            if (accept) begin
               cnt_d   = in_data;
               sum_d   = sum_next;
               state_d = (in_data != ZERO) ? S_DATA : S_CSUM;
            end
         end
         S_DATA: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q;
               wr_data_d = in_data;
               ptr_d     = ptr_q + ONE;
               sum_d     = sum_next;
               cnt_d     = cnt_q - ONE;
               if (cnt_q == ONE) begin
                  state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               if (sum_next == ZERO) begin
                  state_d = S_DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_SYNC;
               end
            end
         end
         S_DONE:  state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         default: state_d = S_SYNC;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_SYNC;
         ptr_q     <= ZERO;
         cnt_q     <= ZERO;
         sum_q     <= ZERO;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= ZERO;
         wr_data_q <= ZERO;
         sync_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         err_q     <= err_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         sync_q    <= sync_d;
      end
   end

   // Once running, the core owns the memory write port with no added latency.
   assign mem_wr_en   = (state_q == S_RUN) ? core_wr_en   : wr_en_q;
   assign mem_wr_addr = (state_q == S_RUN) ? core_wr_addr : wr_addr_q;
   assign mem_wr_data = (state_q == S_RUN) ? core_wr_data : wr_data_q;

   assign core_reset = (state_q != S_RUN);
   assign done       = (state_q == S_DONE) || (state_q == S_RUN);
   assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - randomized frame-level bench for boot_loader
// Expected writes and outcomes are derived per frame from the address, length, data and checksum bytes.
module tb_boot_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] core_wr_data = 8'h00;
   logic [7:0] core_wr_addr = 8'h00;
   logic       core_wr_en = 1'b0;
   logic [7:0] mem_wr_data;
   logic [7:0] mem_wr_addr;
   logic       mem_wr_en;
   logic       core_reset;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;
   bit run_mode = 1'b0;
   logic [15:0] exp_wr[$];
   logic [15:0] mon_w;

   always #5 clk = ~clk;

   boot_loader dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .core_wr_data (core_wr_data),
      .core_wr_addr (core_wr_addr),
      .core_wr_en   (core_wr_en),
      .mem_wr_data  (mem_wr_data),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_en    (mem_wr_en),
      .core_reset   (core_reset),
      .done         (done),
      .err          (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Every loader write must land exactly one cycle after its data byte is accepted.
   always @(negedge clk) begin
      if (reset && !run_mode) begin
         if (exp_wr.size() > 0) begin
            mon_w = exp_wr.pop_front();
            check_eq("wr_en", {31'd0, mem_wr_en}, 32'd1);
            check_eq("wr_addr", {24'd0, mem_wr_addr}, {24'd0, mon_w[15:8]});
            check_eq("wr_data", {24'd0, mem_wr_data}, {24'd0, mon_w[7:0]});
         end else if (mem_wr_en) begin
            check_eq("spurious_wr", {31'd0, mem_wr_en}, 32'd0);
         end
      end
   end

   task automatic do_reset();
      #1;
      reset = 1'b0;
      exp_wr.delete();
      run_mode = 1'b0;
      #1;
      check_eq("rst_core_reset", {31'd0, core_reset}, 32'd1);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      check_eq("rst_done", {31'd0, done}, 32'd0);
      check_eq("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rdy_first_edge", {31'd0, in_ready}, 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit wr, input logic [7:0] a, input int max_gap);
      int gap;
      int guard;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(posedge clk);
         #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!in_ready) begin
         check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (wr) exp_wr.push_back({a, b});
   endtask

   task automatic send_frame(input logic [7:0] addr, input logic [7:0] data[$], input logic [7:0] csum,
                             input int max_gap);
      int  total;
      bit  ok;
      total = int'(addr) + data.size() + int'(csum);
      foreach (data[i]) total += int'(data[i]);
      ok = (total % 256) == 0;
      send_byte(8'hA5, 1'b0, 8'h00, max_gap);
      check_eq("err_clr_on_sync", {31'd0, err}, 32'd0);
      send_byte(addr, 1'b0, 8'h00, max_gap);
      send_byte(8'(data.size()), 1'b0, 8'h00, max_gap);
      foreach (data[i]) send_byte(data[i], 1'b1, 8'(int'(addr) + i), max_gap);
      send_byte(csum, 1'b0, 8'h00, max_gap);
      if (ok) begin
         check_eq("good_done", {31'd0, done}, 32'd1);
         check_eq("good_err", {31'd0, err}, 32'd0);
         check_eq("good_core_rst_held", {31'd0, core_reset}, 32'd1);
         check_eq("good_ready_low", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
         run_mode = 1'b1;
         check_eq("run_core_reset", {31'd0, core_reset}, 32'd0);
         check_eq("run_done", {31'd0, done}, 32'd1);
         check_eq("run_ready", {31'd0, in_ready}, 32'd0);
      end else begin
         check_eq("bad_err", {31'd0, err}, 32'd1);
         check_eq("bad_done", {31'd0, done}, 32'd0);
         check_eq("bad_core_reset", {31'd0, core_reset}, 32'd1);
         check_eq("bad_ready", {31'd0, in_ready}, 32'd1);
      end
   endtask

   task automatic run_passthrough(input int cycles, input bit fixed_first);
      logic [7:0] a, d;
      logic       e;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (fixed_first && i == 0) begin
            a = 8'h40; d = 8'h7E; e = 1'b1;
         end else begin
            a = 8'($urandom); d = 8'($urandom); e = 1'($urandom);
         end
         core_wr_addr = a;
         core_wr_data = d;
         core_wr_en   = e;
         in_valid     = i[0];
         in_data      = 8'($urandom);
         #1;
         check_eq("pass_en", {31'd0, mem_wr_en}, {31'd0, e});
         check_eq("pass_addr", {24'd0, mem_wr_addr}, {24'd0, a});
         check_eq("pass_data", {24'd0, mem_wr_data}, {24'd0, d});
         check_eq("pass_ready", {31'd0, in_ready}, 32'd0);
         check_eq("pass_core_reset", {31'd0, core_reset}, 32'd0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic busy_core();
      core_wr_en   = 1'b1;
      core_wr_addr = 8'($urandom);
      core_wr_data = 8'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] b;
      int         len, total;
      logic [7:0] addr;

      do_reset();
      busy_core();
      q = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h10, q, 8'h87, 0);
      run_passthrough(6, 1'b1);

      do_reset();
      busy_core();
      q = '{8'h01, 8'h02, 8'h03};
      send_frame(8'hFE, q, 8'hF9, 0);

      do_reset();
      busy_core();
      q = '{8'h44};
      send_frame(8'h10, q, 8'h00, 0);
      q = '{8'h55};
      send_frame(8'h10, q, 8'h9A, 0);

      do_reset();
      busy_core();
      send_byte(8'h00, 1'b0, 8'h00, 3);
      send_byte(8'h5A, 1'b0, 8'h00, 3);
      send_byte(8'hFF, 1'b0, 8'h00, 3);
      q.delete();
      send_frame(8'h20, q, 8'hE0, 3);

      do_reset();
      busy_core();
      send_byte(8'hA5, 1'b0, 8'h00, 0);
      send_byte(8'h10, 1'b0, 8'h00, 0);
      send_byte(8'h03, 1'b0, 8'h00, 0);
      send_byte(8'hAB, 1'b1, 8'h10, 0);
      check_eq("mid_wr_pending", {31'd0, mem_wr_en}, 32'd1);
      in_data  = 8'hCD;
      in_valid = 1'b1;
      do_reset();
      in_valid = 1'b0;
      q = '{8'h11, 8'h22, 8'h33};
      send_frame(8'h10, q, 8'h87, 2);

      for (int it = 0; it < 8; it++) begin
         do_reset();
         busy_core();
         repeat ($urandom_range(3, 0)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, 1'b0, 8'h00, 2);
         end
         addr = 8'($urandom);
         len  = int'($urandom_range(6, 0));
         q.delete();
         total = int'(addr) + len;
         for (int i = 0; i < len; i++) begin
            q.push_back(8'($urandom));
            total += int'(q[i]);
         end
         if ($urandom_range(1, 0) == 1) begin
            send_frame(addr, q, 8'(256 - (total % 256) + int'($urandom_range(255, 1))), 2);
         end
         send_frame(addr, q, 8'(256 - (total % 256)), 2);
         run_passthrough(3, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
